// File: rtl/sensor_scan_ctrl.sv
// Sequences an external 7:1 sensor mux, samples each sensor after a settle delay,
// and raises a debounced alarm when enough sensors stay active across scans.
module sensor_scan_ctrl #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned THRESH  = 6,
  parameter int unsigned CONFIRM = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       SensorIn,
  output logic [2:0] Sel,
  output logic       SampleStrobe,
  output logic [6:0] Snapshot,
  output logic [2:0] Count,
  output logic       ScanDone,
  output logic       Alarm
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_EVAL   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] THRESH_V    = 3'(THRESH);
  localparam logic [2:0] CONFIRM_V   = 3'(CONFIRM);
  localparam logic [2:0] SEL_LAST    = 3'd6;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] sel_q, sel_d;
  logic [6:0] scan_q, scan_d;
  logic [6:0] snap_q, snap_d;
  logic [2:0] count_q, count_d;
  logic [2:0] hit_q, hit_d;
  logic       alarm_q, alarm_d;
  logic       strobe_q, strobe_d;
  logic       done_q, done_d;
  logic [2:0] pop_s;
  logic [2:0] hit_next_s;

  // Next-state logic; strobe and done are asserted for the state being entered
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    sel_d      = sel_q;
    scan_d     = scan_q;
    snap_d     = snap_q;
    count_d    = count_q;
    hit_d      = hit_q;
    alarm_d    = alarm_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    pop_s      = popcount7(scan_q);
    hit_next_s = (hit_q >= CONFIRM_V) ? CONFIRM_V : (hit_q + 3'd1);

    case (state_q)
      S_IDLE: begin
        sel_d    = 3'd0;
        settle_d = 4'd0;
        if (Enable) begin
          state_d = S_SETTLE;
          scan_d  = 7'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (!Enable) begin
          state_d  = S_IDLE;
          sel_d    = 3'd0;
          settle_d = 4'd0;
          scan_d   = 7'd0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = S_SAMPLE;
          settle_d = 4'd0;
          strobe_d = 1'b1;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        if (!Enable) begin
          // Partial scan is dropped; results and hit history are untouched
          state_d  = S_IDLE;
          sel_d    = 3'd0;
          settle_d = 4'd0;
          scan_d   = 7'd0;
        end else begin
          scan_d[sel_q] = SensorIn;
          if (sel_q == SEL_LAST) begin
            state_d = S_EVAL;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            sel_d    = sel_q + 3'd1;
            settle_d = 4'd0;
          end
        end
      end
      S_EVAL: begin
        snap_d   = scan_q;
        count_d  = pop_s;
        sel_d    = 3'd0;
        settle_d = 4'd0;
        if (pop_s >= THRESH_V) begin
          hit_d   = hit_next_s;
          alarm_d = (hit_next_s == CONFIRM_V);
        end else begin
          hit_d   = 3'd0;
          alarm_d = 1'b0;
        end
        if (Enable) begin
          state_d = S_SETTLE;
          scan_d  = 7'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        sel_d    = 3'd0;
        settle_d = 4'd0;
        scan_d   = 7'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      settle_q <= 4'd0;
      sel_q    <= 3'd0;
      scan_q   <= 7'd0;
      snap_q   <= 7'd0;
      count_q  <= 3'd0;
      hit_q    <= 3'd0;
      alarm_q  <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      scan_q   <= scan_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      hit_q    <= hit_d;
      alarm_q  <= alarm_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign Sel          = sel_q;
  assign SampleStrobe = strobe_q;
  assign Snapshot     = snap_q;
  assign Count        = count_q;
  assign ScanDone     = done_q;
  assign Alarm        = alarm_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_sensor_scan_ctrl;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic       SensorIn;
  logic [2:0] Sel;
  logic       SampleStrobe;
  logic [6:0] Snapshot;
  logic [2:0] Count;
  logic       ScanDone;
  logic       Alarm;

  logic [6:0] pattern;
  int         vectors;
  int         miscompares;
  int         overlap;

  sensor_scan_ctrl #(.SETTLE(2), .THRESH(6), .CONFIRM(3)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .SensorIn(SensorIn),
    .Sel(Sel), .SampleStrobe(SampleStrobe), .Snapshot(Snapshot),
    .Count(Count), .ScanDone(ScanDone), .Alarm(Alarm)
  );

  // The external mux: SensorIn reflects the addressed sensor
  assign SensorIn = pattern[Sel];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
    if (SampleStrobe && ScanDone) overlap++;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Advance until ScanDone is seen or budget expires; n = cycles taken
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (ScanDone) break;
    end
    if (!ScanDone) n = -1;
  endtask

  task automatic run_to_alarm;
    int n;
    for (int s = 0; s < 3; s++) wait_done(30, n);
    tick();
  endtask

  task automatic test_reset;
    Reset = 1'b1; Enable = 1'b1; pattern = 7'h7F;
    tick(); tick();
    vectors++;
    if ({Sel, SampleStrobe, Snapshot, Count, ScanDone, Alarm} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {Sel, SampleStrobe, Snapshot, Count, ScanDone, Alarm});
    end
    Reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({SampleStrobe, Sel} !== {(k == 3), 3'd0}) begin
        miscompares++;
        $display("FAIL first_strobe cycle %0d: strobe=%0b sel=%0d expected strobe=%0b sel=0",
                 k, SampleStrobe, Sel, (k == 3));
      end
    end
  endtask

  task automatic test_all_active;
    int n;
    do_reset();
    pattern = 7'h7F; Enable = 1'b1; overlap = 0;
    wait_done(30, n);
    vectors++;
    if (n !== 22 || Snapshot !== 7'h00 || Alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL first_scan: cycles=%0d snap=%h alarm=%0b expected 22/00/0", n, Snapshot, Alarm);
    end
    wait_done(30, n);
    vectors++;
    if (n !== 22 || Snapshot !== 7'h7F || Count !== 3'd7 || Alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL second_scan: cycles=%0d snap=%h count=%0d alarm=%0b expected 22/7f/7/0",
               n, Snapshot, Count, Alarm);
    end
    wait_done(30, n);
    vectors++;
    if (n !== 22 || Alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL third_scan: cycles=%0d alarm=%0b expected 22/0", n, Alarm);
    end
    tick();
    vectors++;
    if ({Alarm, Snapshot, Count} !== {1'b1, 7'h7F, 3'd7}) begin
      miscompares++;
      $display("FAIL alarm_rise: alarm=%0b snap=%h count=%0d expected 1/7f/7", Alarm, Snapshot, Count);
    end
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL strobe_done_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  task automatic test_threshold_edge;
    int n;
    do_reset();
    pattern = 7'h3F; Enable = 1'b1;
    run_to_alarm();
    vectors++;
    if ({Alarm, Count, Snapshot} !== {1'b1, 3'd6, 7'h3F}) begin
      miscompares++;
      $display("FAIL thresh_hit: alarm=%0b count=%0d snap=%h expected 1/6/3f", Alarm, Count, Snapshot);
    end
    pattern = 7'h1F;
    wait_done(30, n);
    tick();
    vectors++;
    if ({Alarm, Count, Snapshot} !== {1'b0, 3'd5, 7'h1F}) begin
      miscompares++;
      $display("FAIL thresh_miss: alarm=%0b count=%0d snap=%h expected 0/5/1f", Alarm, Count, Snapshot);
    end
    // Hit history must restart from zero: two hits are not enough
    pattern = 7'h3F;
    wait_done(30, n); wait_done(30, n); tick();
    vectors++;
    if (Alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_cleared: alarm=%0b expected 0", Alarm);
    end
    wait_done(30, n); tick();
    vectors++;
    if (Alarm !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_rebuild: alarm=%0b expected 1", Alarm);
    end
  endtask

  task automatic test_select_seq;
    do_reset();
    pattern = 7'h10; Enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick();
      vectors++;
      if ({Sel, SampleStrobe, ScanDone} !== {3'((k - 1) / 3), (k % 3 == 0), 1'b0}) begin
        miscompares++;
        $display("FAIL sel_seq cycle %0d: sel=%0d strobe=%0b done=%0b expected sel=%0d strobe=%0b done=0",
                 k, Sel, SampleStrobe, ScanDone, (k - 1) / 3, (k % 3 == 0));
      end
    end
    tick();
    Enable = 1'b0;
    vectors++;
    if (ScanDone !== 1'b1) begin
      miscompares++;
      $display("FAIL sel_done: done=%0b expected 1", ScanDone);
    end
    tick();
    vectors++;
    if ({Snapshot, Count, Alarm, Sel} !== {7'h10, 3'd1, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL sel_result: snap=%h count=%0d alarm=%0b sel=%0d expected 10/1/0/0",
               Snapshot, Count, Alarm, Sel);
    end
  endtask

  task automatic test_abort;
    int n;
    int dones;
    do_reset();
    pattern = 7'h7F; Enable = 1'b1;
    run_to_alarm();
    for (int k = 0; k < 9; k++) tick();
    vectors++;
    if (Sel !== 3'd3) begin
      miscompares++;
      $display("FAIL abort_setup: sel=%0d expected 3", Sel);
    end
    Enable = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ScanDone) dones++;
    end
    vectors++;
    if ({Sel, SampleStrobe, Snapshot, Count, Alarm, 3'(dones)} !== {3'd0, 1'b0, 7'h7F, 3'd7, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL abort_hold: sel=%0d strobe=%0b snap=%h count=%0d alarm=%0b dones=%0d expected 0/0/7f/7/1/0",
               Sel, SampleStrobe, Snapshot, Count, Alarm, dones);
    end
    Enable = 1'b1;
    wait_done(30, n);
    vectors++;
    if (n !== 22 || Alarm !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_restart: cycles=%0d alarm=%0b expected 22/1", n, Alarm);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    pattern = 7'h7F; Enable = 1'b1;
    run_to_alarm();
    for (int k = 0; k < 17; k++) tick();
    vectors++;
    if ({SampleStrobe, Sel, Alarm} !== {1'b1, 3'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL rmid_setup: strobe=%0b sel=%0d alarm=%0b expected 1/5/1", SampleStrobe, Sel, Alarm);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++;
    if ({Sel, SampleStrobe, Snapshot, Count, ScanDone, Alarm} !== 16'h0000) begin
      miscompares++;
      $display("FAIL rmid_outputs: got %h expected 0000",
               {Sel, SampleStrobe, Snapshot, Count, ScanDone, Alarm});
    end
    wait_done(30, n);
    vectors++;
    if (n !== 22) begin
      miscompares++;
      $display("FAIL rmid_restart: cycles=%0d expected 22", n);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; overlap = 0;
    Reset = 1'b1; Enable = 1'b0; pattern = 7'h00;
    test_reset();
    test_all_active();
    test_threshold_edge();
    test_select_seq();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
